uart_rx_module: RTL and testbench

- UART receiver, 8N1 (one start bit low, 8 data bits LSB-first, one stop bit high), idle line high.
- Mirror of the screen/UART transmit path. Receives frames from the screen or host into the piano core.
- Delivers each byte through a 1-entry output register with a valid/ready handshake.
- Flags framing errors, overruns and, optionally, parity errors.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_module_if.sv | 13 +
 rtl/uart_rx_module_sync_2ff.sv | 26 ++
 rtl/uart_rx_module.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_module.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive and transmit paths.
//   uartState_e     - receiver FSM states
//   BAUD_RATE_DIV   - default clocks per bit (50 MHz / 9600 baud)
//   FRAME_DATA_BITS - data bits per frame, sent LSB first
//   LINE_IDLE       - idle / stop level of the serial line
//   START_LEVEL     - start bit level
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4,
    BREAK  = 3'd5
  } uartState_e;

  localparam int   BAUD_RATE_DIV   = 5208;
  localparam int   FRAME_DATA_BITS = 8;
  localparam logic LINE_IDLE       = 1'b1;
  localparam logic START_LEVEL     = 1'b0;

endpackage

// File: rtl/uart_rx_module_if.sv
// uart_rx_module_if: received-byte handshake between the UART receiver and its consumer.
//   odata  - received byte, held stable while ovalid=1 and iready=0
//   ovalid - odata holds an unconsumed byte
//   iready - consumer takes odata on a rising edge where ovalid & iready
// master = receiver side, slave = consumer side.
interface uart_rx_module_if;
  logic [7:0] odata;
  logic       ovalid;
  logic       iready;

  modport master (output odata, output ovalid, input iready);
  modport slave  (input odata, input ovalid, output iready);
endinterface

// File: rtl/uart_rx_module_sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input.
//   clk, reset - system clock, synchronous active-high reset
//   din        - asynchronous input
//   dout       - synchronized output, RESET_VAL while in reset
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      dout <= RESET_VAL;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_module.sv
// uart_rx_module: 8N1 UART receiver (optional even parity) with a one-entry output register.
//   clk, reset  - system clock, synchronous active-high reset
//   rx_in       - asynchronous serial line, idle high
//   rxBus       - master side of the odata/ovalid/iready handshake
//   busy        - FSM is in any state other than IDLE
//   frame_err   - one-cycle pulse when the stop bit samples 0
//   overrun     - one-cycle pulse when a completed byte is dropped because the register is full
//   parity_err  - one-cycle pulse on parity mismatch (constant 0 unless parity is built in)
//   dbgState    - current FSM state
// Build option: define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
//
// Handshake: a byte is transferred on every rising edge where ovalid & iready are both 1;
// ovalid stays high and odata stays constant until that edge, and a new byte may be loaded
// on the same edge as the old one is taken.
module uart_rx_module
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_RATE_DIV,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_in,
  uart_rx_module_if.master  rxBus,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err,
  output uartState_e        dbgState
);

  localparam logic [13:0] BAUD_LAST = 14'(BAUD_DIV - 1);
  localparam logic [13:0] HALF_LAST = 14'(HALF_DIV - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(FRAME_DATA_BITS - 1);

  uartState_e  state;
  logic        rx_s;
  logic        rx_prev;
  logic [13:0] divCount;
  logic [3:0]  bitCount;
  logic [7:0]  shift;
  logic [7:0]  odataQ;
  logic        ovalidQ;
  logic        halfDone;
  logic        baudDone;
  logic        parityGood;
  logic        canLoad;
  logic        stopGood;

  sync_2ff #(.RESET_VAL(LINE_IDLE)) rxSync (
    .clk  (clk),
    .reset(reset),
    .din  (rx_in),
    .dout (rx_s)
  );

  assign halfDone = (divCount == HALF_LAST);
  assign baudDone = (divCount == BAUD_LAST);
  // The register can take a new byte if empty or if its current byte leaves this edge.
  assign canLoad  = !ovalidQ || rxBus.iready;
  // Stop sample of a frame that is fit for delivery.
  assign stopGood = (state == STOP) && baudDone && (rx_s == LINE_IDLE) && parityGood;

`ifdef UART_RX_PARITY_EN
  logic parBit;
  logic parErrQ;
  assign parityGood = ((^shift) ^ parBit) == 1'b0;
  assign parity_err = parErrQ;
`else
  assign parityGood = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rx_prev   <= LINE_IDLE;
      divCount  <= '0;
      bitCount  <= '0;
      shift     <= '0;
      odataQ    <= '0;
      ovalidQ   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parBit    <= 1'b0;
      parErrQ   <= 1'b0;
`endif
    end else begin
      rx_prev   <= rx_s;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parErrQ   <= 1'b0;
`endif
      divCount  <= divCount + 14'd1;

      case (state)
        IDLE: begin
          divCount <= '0;
          if (rx_prev == LINE_IDLE && rx_s == START_LEVEL) state <= START;
        end
        START: begin
          if (halfDone) begin
            divCount <= '0;
            // A line that is high again at mid start bit was a glitch.
            state    <= (rx_s == START_LEVEL) ? DATA : IDLE;
          end
        end
        DATA: begin
          if (baudDone) begin
            divCount              <= '0;
            shift[bitCount[2:0]]  <= rx_s;
            if (bitCount == LAST_BIT) begin
              bitCount <= '0;
`ifdef UART_RX_PARITY_EN
              state    <= PARITY;
`else
              state    <= STOP;
`endif
            end else begin
              bitCount <= bitCount + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baudDone) begin
            divCount <= '0;
            parBit   <= rx_s;
            state    <= STOP;
          end
        end
`endif
        STOP: begin
          if (baudDone) begin
            divCount <= '0;
`ifdef UART_RX_PARITY_EN
            parErrQ  <= !parityGood;
`endif
            if (rx_s == LINE_IDLE) begin
              state <= IDLE;
              // Bad-parity bytes are discarded and never count as overrun.
              if (parityGood && !canLoad) overrun <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          // Hold here until the line is released so a stuck-low line cannot start a frame.
          divCount <= '0;
          if (rx_s == LINE_IDLE) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          divCount <= '0;
          bitCount <= '0;
        end
      endcase

      if (stopGood && canLoad) begin
        odataQ  <= shift;
        ovalidQ <= 1'b1;
      end else if (ovalidQ && rxBus.iready) begin
        ovalidQ <= 1'b0;
      end
    end
  end

  assign rxBus.odata  = odataQ;
  assign rxBus.ovalid = ovalidQ;
  assign busy         = (state != IDLE);
  assign dbgState     = state;

endmodule

// File: tb/tb_uart_rx_module.sv
// tb_uart_rx_module: self-checking bench for uart_rx_module with BAUD_DIV=16.
// Frames are driven bit by bit on rx_in; a frame-level model predicts which bytes are
// delivered and how many frame/overrun/parity flags appear, and a negedge monitor
// compares delivered bytes against the expected queue.
module tb_uart_rx_module;
  import uart_pkg::*;

  localparam int BAUD = 16;
  localparam int HALF = BAUD / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Edges from the start edge to ovalid: 2 synchronizer flops, 1 edge detect, half a bit,
  // then data (+parity) and stop bits each one full bit apart.
  localparam int LAT = 3 + HALF + (FRAME_DATA_BITS + 1 + int'(PAR_EN)) * BAUD;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_in = 1'b1;
  logic       busy, frame_err, overrun, parity_err;
  uartState_e dbg_state;

  uart_rx_module_if rx_bus();

  uart_rx_module #(.BAUD_DIV(BAUD), .HALF_DIV(HALF)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .rxBus     (rx_bus),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err),
    .dbgState  (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int exp_ferr = 0, exp_ovr = 0, exp_perr = 0, exp_acc = 0;
  int act_ferr = 0, act_ovr = 0, act_perr = 0, act_acc = 0;
  bit model_full = 1'b0;
  logic [7:0] held_data;
  bit holding = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_err"}, act_ferr, exp_ferr);
    check({tag, "_overrun"}, act_ovr, exp_ovr);
    check({tag, "_parity_err"}, act_perr, exp_perr);
    check({tag, "_accepted"}, act_acc, exp_acc);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) act_ferr++;
      if (overrun) act_ovr++;
      if (parity_err) act_perr++;
      if (rx_bus.ovalid && !rx_bus.iready) begin
        if (holding) check("odata_stable", rx_bus.odata, held_data);
        held_data = rx_bus.odata;
        holding = 1'b1;
      end else begin
        holding = 1'b0;
      end
      if (rx_bus.ovalid && rx_bus.iready) begin
        act_acc++;
        check("byte_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("odata", rx_bus.odata, exp_q.pop_front());
      end
    end
  end

  // Frame-level model: what the receiver must do with one whole frame.
  task automatic model_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    bit par_ok;
    par_ok = !(PAR_EN && par_flip);
    if (!stop_b) begin
      exp_ferr++;
      if (!par_ok) exp_perr++;
    end else if (!par_ok) begin
      exp_perr++;
    end else if (rx_bus.iready) begin
      exp_q.push_back(d);
      exp_acc++;
    end else if (!model_full) begin
      exp_q.push_back(d);
      model_full = 1'b1;
    end else begin
      exp_ovr++;
    end
  endtask

  task automatic set_ready(input logic v);
    rx_bus.iready = v;
    if (v && model_full) begin
      exp_acc++;
      model_full = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  // All driving happens 1 time unit after a rising edge.
  task automatic hold_line(input logic b, input int n);
    rx_in = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    logic par_bit;
    par_bit = (^d) ^ par_flip;
    hold_line(START_LEVEL, BAUD);
    for (int i = 0; i < FRAME_DATA_BITS; i++) hold_line(d[i], BAUD);
    if (PAR_EN) hold_line(par_bit, BAUD);
    hold_line(stop_b, BAUD);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit saw_busy;
    logic [7:0] d;
    logic stop_b, flip;

    rx_bus.iready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ovalid", rx_bus.ovalid, 0);
    check("rst_odata", rx_bus.odata, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_state", dbg_state, IDLE);
    @(posedge clk);
    #1;
    reset = 1'b0;
    hold_line(1'b1, BAUD);

    // 0xA5 with consumer ready: exact delivery latency and a one-cycle ovalid pulse.
    model_frame(8'hA5, 1'b1, 1'b0);
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        n = 0;
        while (n < 400) begin
          @(posedge clk);
          #1;
          n++;
          if (rx_bus.ovalid) break;
        end
        check("a5_latency", n, LAT);
        @(posedge clk);
        #1;
        check("a5_pulse_width", rx_bus.ovalid, 0);
      end
    join
    hold_line(1'b1, BAUD);
    check_counts("a5");

    // Four-cycle low glitch on an idle line.
    saw_busy = 1'b0;
    rx_in = 1'b0;
    for (int i = 1; i <= HALF + 3; i++) begin
      @(posedge clk);
      #1;
      if (i == 4) rx_in = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    check("glitch_busy_seen", saw_busy, 1);
    check("glitch_busy_drop", busy, 0);
    check("glitch_ovalid", rx_bus.ovalid, 0);
    hold_line(1'b1, BAUD);
    check_counts("glitch");

    // 0x3C with a low stop bit, line then held low.
    model_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    hold_line(1'b0, 40);
    check("ferr_busy_held", busy, 1);
    hold_line(1'b1, 4);
    check("ferr_busy_released", busy, 0);
    hold_line(1'b1, BAUD);
    check_counts("ferr");

    // Consumer stalled, two back-to-back frames: second is an overrun.
    set_ready(1'b0);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    model_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    hold_line(1'b1, BAUD);
    check("ovr_odata", rx_bus.odata, 8'h11);
    check("ovr_ovalid", rx_bus.ovalid, 1);
    check_counts("ovr_stalled");
    set_ready(1'b1);
    @(posedge clk);
    #1;
    check("ovr_release", rx_bus.ovalid, 0);
    hold_line(1'b1, BAUD);
    check_counts("ovr");

    // Reset in the middle of the data bits of 0xFF, then a clean 0x5A.
    hold_line(START_LEVEL, BAUD);
    hold_line(1'b1, 3 * BAUD);
    reset = 1'b1;
    hold_line(1'b1, 2);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_ovalid", rx_bus.ovalid, 0);
    check("midrst_state", dbg_state, IDLE);
    hold_line(1'b1, BAUD);
    model_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    hold_line(1'b1, BAUD);
    check_counts("midrst");

`ifdef UART_RX_PARITY_EN
    // 0x07: parity bit 1 is correct even parity, parity bit 0 is not.
    model_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    hold_line(1'b1, BAUD);
    model_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    hold_line(1'b1, BAUD);
    model_frame(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1);
    hold_line(1'b1, BAUD);
    check_counts("parity");
`endif

    // Random frames: random data, occasional bad stop/parity, consumer stalls, 0..1 bit gaps.
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom_range(0, 255));
      stop_b = ($urandom_range(0, 5) != 0);
      flip = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0) set_ready(1'($urandom_range(0, 1)));
      model_frame(d, stop_b, flip);
      send_frame(d, stop_b, flip);
      if (!stop_b) hold_line(1'b1, BAUD);
      else if ($urandom_range(0, 1) == 1) hold_line(1'b1, $urandom_range(1, BAUD));
    end
    set_ready(1'b1);
    hold_line(1'b1, 2 * BAUD);
    check_counts("random");
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
